// File: rtl/chi_plane_codec.sv
// Masking front/back end for a three-share Keccak chi core: shares one plane, streams five rows, collects results.
// Build option CHI_CODEC_UNMASK_EN: when defined, out_plane carries the recombined result; otherwise it is tied to 0.
module chi_plane_codec (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [24:0] in_plane,
    input  logic [49:0] in_rnd,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  core_in1,
    output logic [4:0]  core_in2,
    output logic [4:0]  core_in3,
    input  logic [4:0]  core_out1,
    input  logic [4:0]  core_out2,
    input  logic [4:0]  core_out3,
    output logic [24:0] out_share1,
    output logic [24:0] out_share2,
    output logic [24:0] out_share3,
    output logic [24:0] out_plane,
    output logic        out_valid,
    input  logic        out_ready
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never depends combinationally on ready, and a presented result holds until taken.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      r_state;
    logic [2:0]  r_row_cnt;
    logic [24:0] r_sh1;
    logic [24:0] r_sh2;
    logic [24:0] r_sh3;
    logic        r_cap_en;
    logic [2:0]  r_cap_row;
    logic [24:0] r_out_sh1;
    logic [24:0] r_out_sh2;
    logic [24:0] r_out_sh3;
    logic        r_out_valid;
    logic        r_in_ready;

    logic [24:0] w_sh1;
    logic [24:0] w_sh2;
    logic [24:0] w_sh3;
    logic [4:0]  w_row1;
    logic [4:0]  w_row2;
    logic [4:0]  w_row3;
    logic        w_accept;

    assign w_accept = in_valid & r_in_ready;

    // Shares 2 and 3 come straight from the randomness; share 1 absorbs the plane.
    always_comb begin
        w_sh1 = '0;
        w_sh2 = '0;
        w_sh3 = '0;
        for (int r = 0; r < 5; r++) begin
            w_sh2[5*r +: 5] = in_rnd[10*r +: 5];
            w_sh3[5*r +: 5] = in_rnd[10*r + 5 +: 5];
            w_sh1[5*r +: 5] = in_plane[5*r +: 5] ^ in_rnd[10*r +: 5] ^ in_rnd[10*r + 5 +: 5];
        end
    end

    always_comb begin
        w_row1 = '0;
        w_row2 = '0;
        w_row3 = '0;
        for (int r = 0; r < 5; r++) begin
            if (r_row_cnt == 3'(r)) begin
                w_row1 = r_sh1[5*r +: 5];
                w_row2 = r_sh2[5*r +: 5];
                w_row3 = r_sh3[5*r +: 5];
            end
        end
    end

    assign core_in1 = (r_state == S_FEED) ? w_row1 : 5'd0;
    assign core_in2 = (r_state == S_FEED) ? w_row2 : 5'd0;
    assign core_in3 = (r_state == S_FEED) ? w_row3 : 5'd0;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= 3'd0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            r_sh3       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sh1      <= w_sh1;
                        r_sh2      <= w_sh2;
                        r_sh3      <= w_sh3;
                        r_row_cnt  <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FEED;
                    end
                end
                S_FEED: begin
                    if (r_row_cnt == 3'd4) begin
                        r_row_cnt <= 3'd0;
                        r_state   <= S_DRAIN;
                    end else begin
                        r_row_cnt <= r_row_cnt + 3'd1;
                    end
                end
                S_DRAIN: begin
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The core registers its outputs, so the row being written is the one fed a cycle earlier.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_cap_en  <= 1'b0;
            r_cap_row <= 3'd0;
            r_out_sh1 <= '0;
            r_out_sh2 <= '0;
            r_out_sh3 <= '0;
        end else begin
            r_cap_en  <= (r_state == S_FEED);
            r_cap_row <= r_row_cnt;
            if (r_cap_en) begin
                for (int r = 0; r < 5; r++) begin
                    if (r_cap_row == 3'(r)) begin
                        r_out_sh1[5*r +: 5] <= core_out1;
                        r_out_sh2[5*r +: 5] <= core_out2;
                        r_out_sh3[5*r +: 5] <= core_out3;
                    end
                end
            end
        end
    end

`ifdef CHI_CODEC_UNMASK_EN
    logic [24:0] r_out_plane;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_out_plane <= '0;
        end else if (r_cap_en) begin
            for (int r = 0; r < 5; r++) begin
                if (r_cap_row == 3'(r)) begin
                    r_out_plane[5*r +: 5] <= core_out1 ^ core_out2 ^ core_out3;
                end
            end
        end
    end

    assign out_plane = r_out_plane;
`else
    // Result stays masked so it can feed further masked rounds.
    assign out_plane = '0;
`endif

    assign out_share1 = r_out_sh1;
    assign out_share2 = r_out_sh2;
    assign out_share3 = r_out_sh3;
    assign out_valid  = r_out_valid;
    assign in_ready   = r_in_ready;

endmodule
